mul16_seq_ctrl: RTL and testbench

- Sequential 16x16 unsigned multiplier controller.
- Time-multiplexes one instance of the team's combinational 8x8 array multiplier (Multiplier8x8_CSA) over four partial-product steps and accumulates the results into a 32-bit product.
- Operand input and result output each use a valid/ready handshake.
- Sits between a requesting datapath (e.g. BCD/arith pipeline) and the shared 8x8 multiplier.

---
 rtl/mul16_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mul16_seq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mul16_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul16_seq_ctrl
//   Sequential 16x16 unsigned multiplier. One combinational 8x8 carry-save
//   array multiplier is reused over four partial-product steps. The partial
//   products are accumulated into a 32-bit product.
//
//   Ports
//     clk        in   system clock, rising edge
//     rst_n      in   synchronous active-low reset
//     in_valid   in   operand pair valid
//     in_ready   out  operands accepted (high only while idle)
//     a, b       in   16-bit unsigned operands
//     out_valid  out  product valid (high only while done)
//     out_ready  in   consumer takes the product
//     product    out  32-bit unsigned result
//     busy       out  operation in flight or result waiting
//
//   Multiplier8x8_CSA
//     i_a, i_b   in   8-bit unsigned operands
//     o_p        out  16-bit unsigned product, purely combinational
// ---------------------------------------------------------------------------

module Multiplier8x8_CSA (
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_p
);
    // Partial-product rows, each already shifted into its column position.
    logic [15:0] w_pp  [8];
    // Running carry-save pair after each row is folded in.
    logic [15:0] w_sum [8];
    logic [15:0] w_cry [8];
    // Majority (carry) of each 3:2 compression, before the left shift.
    logic [15:0] w_maj [7];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pp
            assign w_pp[gi] = {8'h00, i_a & {8{i_b[gi]}}} << gi;
        end
    endgenerate

    assign w_sum[0] = w_pp[0];
    assign w_cry[0] = 16'h0000;

    // Rows 1..7 each go through a 3:2 compressor. The true product fits in
    // 16 bits, so carries shifted past bit 15 can be dropped: the pair stays
    // correct modulo 2^16.
    generate
        for (gi = 1; gi < 8; gi++) begin : g_csa
            assign w_sum[gi]   = w_sum[gi-1] ^ w_cry[gi-1] ^ w_pp[gi];
            assign w_maj[gi-1] = (w_sum[gi-1] & w_cry[gi-1])
                               | (w_sum[gi-1] & w_pp[gi])
                               | (w_cry[gi-1] & w_pp[gi]);
            assign w_cry[gi]   = w_maj[gi-1] << 1;
        end
    endgenerate

    // Final carry-propagate add resolves the carry-save pair.
    assign o_p = w_sum[7] + w_cry[7];
endmodule

module mul16_seq_ctrl #(
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_step;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [31:0] r_acc;

    logic        w_accept;
    logic        w_drain;
    logic        w_zero_op;
    logic [7:0]  w_mul_a;
    logic [7:0]  w_mul_b;
    logic [15:0] w_pp16;
    logic [4:0]  w_shift;
    logic [31:0] w_pp_ext;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_drain   = out_ready && (r_state == S_DONE);
    assign w_zero_op = EARLY_ZERO && ((a == 16'h0000) || (b == 16'h0000));

    // step[0] picks the high byte of b, step[1] the high byte of a:
    //   0: aL*bL  1: aL*bH  2: aH*bL  3: aH*bH
    assign w_mul_a = r_step[1] ? r_a[15:8] : r_a[7:0];
    assign w_mul_b = r_step[0] ? r_b[15:8] : r_b[7:0];

    // Shift is 8 per high byte involved: 0, 8, 8, 16.
    assign w_shift = {r_step[1] & r_step[0], r_step[1] ^ r_step[0], 3'b000};

    Multiplier8x8_CSA u_mul8 (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_pp16)
    );

    assign w_pp_ext = {16'h0000, w_pp16} << w_shift;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_zero_op ? S_DONE : S_CALC;
            S_CALC: if (r_step == 2'd3) w_state_nxt = S_DONE;
            S_DONE: if (w_drain) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= 2'd0;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_acc   <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= 32'h0000_0000;
                        r_step <= 2'd0;
                    end
                end
                S_CALC: begin
                    // Max result 0xFFFE0001, so the 32-bit sum never wraps.
                    r_acc  <= r_acc + w_pp_ext;
                    r_step <= r_step + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    // Holds the last result in IDLE; consumers must qualify with out_valid.
    assign product   = r_acc;
endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul16_seq_ctrl
//   Two instances share stimulus: index 0 without early-zero, index 1 with.
//   A transaction-level model (expected product = a*b, result due a fixed
//   number of cycles after acceptance) is compared on every negedge, and
//   directed operations pin product values and latencies to literals.
// ---------------------------------------------------------------------------

module tb_mul16_seq_ctrl;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [15:0]      a = 16'h0;
    logic [15:0]      b = 16'h0;
    logic [1:0]       in_ready;
    logic [1:0]       out_valid;
    logic [1:0]       busy;
    logic [1:0][31:0] product;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul16_seq_ctrl #(.EARLY_ZERO(1'b0)) u_nz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready),
        .product(product[0]), .busy(busy[0])
    );

    mul16_seq_ctrl #(.EARLY_ZERO(1'b1)) u_ez (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready),
        .product(product[1]), .busy(busy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- transaction model + per-cycle compare ----------------
    bit          known = 1'b0;
    bit          pend  [2];
    int          vat   [2];
    logic [31:0] mexp  [2];
    logic [31:0] mlast [2];
    int          cyc = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit mov;
            mov = pend[k] && (cyc >= vat[k]);
            if (known) begin
                chk($sformatf("in_ready[%0d]", k), {31'b0, in_ready[k]}, {31'b0, !pend[k]});
                chk($sformatf("busy[%0d]", k), {31'b0, busy[k]}, {31'b0, pend[k]});
                chk($sformatf("out_valid[%0d]", k), {31'b0, out_valid[k]}, {31'b0, mov});
                if (mov)
                    chk($sformatf("product[%0d]", k), product[k], mexp[k]);
                else if (!pend[k])
                    chk($sformatf("idle_product[%0d]", k), product[k], mlast[k]);
            end
            if (!rst_n) begin
                pend[k]  = 1'b0;
                mlast[k] = 32'h0;
            end else if (known && !pend[k] && in_valid) begin
                pend[k] = 1'b1;
                mexp[k] = {16'h0, a} * {16'h0, b};
                vat[k]  = cyc + (((k == 1) && (a == 16'h0 || b == 16'h0)) ? 1 : 5);
            end else if (mov && out_ready) begin
                pend[k]  = 1'b0;
                mlast[k] = mexp[k];
            end
        end
        if (!rst_n) known = 1'b1;
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_idle();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready == 2'b11) break;
        end
        chk("return_idle", {30'b0, in_ready}, 32'd3);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input int hold,
                          output int ln, output int le,
                          output logic [31:0] pn, output logic [31:0] pe);
        ln = 0; le = 0; pn = 32'hx; pe = 32'hx;
        @(posedge clk); #1;
        a = ta; b = tb_; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        for (int c = 1; c <= 20 && (ln == 0 || le == 0); c++) begin
            @(negedge clk);
            if (c == 1) chk("ready_drop", {30'b0, in_ready}, 32'd0);
            if (out_valid[0] && ln == 0) begin ln = c; pn = product[0]; end
            if (out_valid[1] && le == 0) begin le = c; pe = product[1]; end
        end
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                if (h > 0) @(negedge clk);
                chk("hold_valid", {30'b0, out_valid}, 32'd3);
                chk("hold_product", product[0], pn);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        wait_idle();
    endtask

    initial begin : stim
        int ln, le;
        logic [31:0] pn, pe;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {30'b0, in_ready}, 32'd3);
        chk("rst_out_valid", {30'b0, out_valid}, 32'd0);
        chk("rst_busy", {30'b0, busy}, 32'd0);
        chk("rst_product", product[0] | product[1], 32'h0);

        run_op(16'h0003, 16'h0005, 0, ln, le, pn, pe);
        chk("lat_3x5", ln, 5); chk("prod_3x5", pn, 32'h0000000F); chk("prod_3x5_ez", pe, 32'h0000000F);

        run_op(16'hFFFF, 16'hFFFF, 0, ln, le, pn, pe);
        chk("prod_max", pn, 32'hFFFE0001); chk("lat_max_ez", le, 5);

        run_op(16'h1234, 16'h5678, 0, ln, le, pn, pe);
        chk("prod_1234", pn, 32'h06260060); chk("lat_1234", ln, 5);

        run_op(16'h00FF, 16'hFF00, 3, ln, le, pn, pe);
        chk("prod_hold", pn, 32'h00FE0100); chk("prod_hold_ez", pe, 32'h00FE0100);

        // Second request pulsed while busy must be ignored.
        @(posedge clk); #1;
        a = 16'h0010; b = 16'h0010; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 a = 16'h0002; b = 16'h0002; in_valid = 1'b1;
        @(negedge clk);
        chk("busy_in_ready", {30'b0, in_ready}, 32'd0);
        @(posedge clk); #1 in_valid = 1'b0; a = 16'h0; b = 16'h0;
        pn = 32'hx;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid[0]) begin pn = product[0]; break; end
        end
        chk("prod_ignored", pn, 32'h00000100);
        wait_idle();
        run_op(16'h0002, 16'h0002, 0, ln, le, pn, pe);
        chk("prod_2x2", pn, 32'h00000004); chk("lat_2x2", ln, 5);

        // Zero operand: early exit only on the EARLY_ZERO instance.
        run_op(16'h0000, 16'hABCD, 0, ln, le, pn, pe);
        chk("lat_zero_ez", le, 1); chk("lat_zero_nz", ln, 5);
        chk("prod_zero_ez", pe, 32'h0); chk("prod_zero_nz", pn, 32'h0);

        // Reset during step2 discards the operation.
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {30'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {30'b0, in_ready}, 32'd3);
        chk("midrst_product", product[0] | product[1], 32'h0);

        run_op(16'h0007, 16'h0009, 0, ln, le, pn, pe);
        chk("prod_7x9", pn, 32'h0000003F); chk("lat_7x9", ln, 5); chk("lat_7x9_ez", le, 5);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
